boot_sram_loader: RTL and testbench



---
 rtl/boot_pkg.sv | 29 ++
 rtl/sram_write_cycle.sv | 53 +++++
 rtl/boot_sram_loader.sv | 131 +++++++++++++
 tb/tb_boot_sram_loader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared boot-path definitions: loader state encoding and default image placement,
// used by boot_sram_loader, sram_write_cycle and the SPI flash boot reader.
package boot_pkg;

  localparam logic [15:0] BOOT_LOAD_BASE   = 16'hE000;
  localparam int          BOOT_LOAD_LENGTH = 8192;

  // LS_WRITE spans the SETUP/STROBE/HOLD phases sequenced by sram_write_cycle.
  typedef enum logic [2:0] {
    LS_WAIT_BYTE,
    LS_WRITE,
    LS_CHECK,
    LS_RELEASE,
    LS_DONE,
    LS_ERROR
  } load_state_t;

  typedef enum logic [1:0] {
    WP_IDLE,
    WP_SETUP,
    WP_STROBE,
    WP_HOLD
  } write_phase_t;

  function automatic logic releases_bus(load_state_t s);
    return (s == LS_RELEASE) || (s == LS_DONE) || (s == LS_ERROR);
  endfunction

endpackage

// File: rtl/sram_write_cycle.sv
// One asynchronous SRAM write: SETUP (1 clk), STROBE (WE_CYCLES clks), HOLD (1 clk).
// o_last marks the HOLD clock so the caller can advance address/count with no idle gap.
module sram_write_cycle
  import boot_pkg::*;
#(
  parameter int WE_CYCLES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_start,
  output logic o_busy,
  output logic o_last,
  output logic o_ce_n,
  output logic o_we_n,
  output logic o_oe
);

  localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

  write_phase_t     r_phase;
  write_phase_t     w_phase_next;
  logic [CNT_W-1:0] r_we_cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_phase  <= WP_IDLE;
      r_we_cnt <= '0;
    end else begin
      r_phase  <= w_phase_next;
      r_we_cnt <= (r_phase == WP_STROBE) ? r_we_cnt + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    w_phase_next = r_phase;
    case (r_phase)
      WP_IDLE:   if (i_start) w_phase_next = WP_SETUP;
      WP_SETUP:  w_phase_next = WP_STROBE;
      WP_STROBE: if (r_we_cnt == CNT_W'(WE_CYCLES - 1)) w_phase_next = WP_HOLD;
      WP_HOLD:   w_phase_next = WP_IDLE;
      default:   w_phase_next = WP_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_phase != WP_IDLE);
    o_last = (r_phase == WP_HOLD);
    o_ce_n = (r_phase == WP_IDLE);
    o_oe   = (r_phase != WP_IDLE);
    o_we_n = (r_phase != WP_STROBE);
  end

endmodule

// File: rtl/boot_sram_loader.sv
// Copies the flash boot image into SRAM while holding the CPU in reset, then releases both.
// Optional trailing checksum byte: define BOOT_SRAM_LOADER_CHECKSUM_EN.
module boot_sram_loader
  import boot_pkg::*;
#(
  parameter int                   ADDR_BITS      = 16,
  parameter logic [ADDR_BITS-1:0] LOAD_BASE      = ADDR_BITS'(BOOT_LOAD_BASE),
  parameter int                   LOAD_LENGTH    = BOOT_LOAD_LENGTH,
  parameter int                   WE_CYCLES      = 2,
  parameter int                   RELEASE_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [7:0]           byte_data,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_data,
  output logic                 ram_data_oe,
  output logic                 ram_ce_n,
  output logic                 ram_we_n,
  output logic                 bus_owned,
  output logic                 cpu_reset_n,
  output logic                 done,
  output logic                 error
);

  localparam int CNT_W = $clog2(LOAD_LENGTH + 1);
  localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  load_state_t          r_state;
  load_state_t          w_state_next;
  logic                 r_byte_ready;
  logic [ADDR_BITS-1:0] r_addr;
  logic [7:0]           r_data;
  logic [CNT_W-1:0]     r_count;
  logic [REL_W-1:0]     r_rel_cnt;
`ifdef BOOT_SRAM_LOADER_CHECKSUM_EN
  logic [7:0]           r_sum;
`endif

  logic w_accept;
  logic w_start;
  logic w_wr_busy;
  logic w_wr_last;
  logic w_write_end;
  logic w_last_byte;

  assign w_accept    = byte_valid && r_byte_ready;
  assign w_start     = (r_state == LS_WAIT_BYTE) && w_accept && !w_wr_busy;
  assign w_write_end = (r_state == LS_WRITE) && w_wr_last;
  assign w_last_byte = (r_count == CNT_W'(LOAD_LENGTH - 1));

  sram_write_cycle #(
    .WE_CYCLES(WE_CYCLES)
  ) u_write_cycle (
    .clock  (clock),
    .reset_n(reset_n),
    .i_start(w_start),
    .o_busy (w_wr_busy),
    .o_last (w_wr_last),
    .o_ce_n (ram_ce_n),
    .o_we_n (ram_we_n),
    .o_oe   (ram_data_oe)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= LS_WAIT_BYTE;
      r_byte_ready <= 1'b0;
      r_addr       <= LOAD_BASE;
      r_data       <= '0;
      r_count      <= '0;
      r_rel_cnt    <= '0;
    end else begin
      r_state      <= w_state_next;
      // Registered from the next state so ready drops the clock after a handshake.
      r_byte_ready <= (w_state_next == LS_WAIT_BYTE) || (w_state_next == LS_CHECK);
      if (w_start) r_data <= byte_data;
      if (w_write_end) begin
        r_count <= r_count + CNT_W'(1);
        if (r_addr != '1) r_addr <= r_addr + ADDR_BITS'(1);
      end
      r_rel_cnt <= (r_state == LS_RELEASE) ? r_rel_cnt + REL_W'(1) : '0;
    end
  end

`ifdef BOOT_SRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (!reset_n)     r_sum <= '0;
    else if (w_start) r_sum <= r_sum + byte_data;
  end
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LS_WAIT_BYTE: if (w_start) w_state_next = LS_WRITE;
      LS_WRITE: begin
        if (w_wr_last) begin
          if (!w_last_byte)   w_state_next = LS_WAIT_BYTE;
`ifdef BOOT_SRAM_LOADER_CHECKSUM_EN
          else                w_state_next = LS_CHECK;
`else
          else                w_state_next = LS_RELEASE;
`endif
        end
      end
`ifdef BOOT_SRAM_LOADER_CHECKSUM_EN
      LS_CHECK: if (w_accept) w_state_next = (byte_data == r_sum) ? LS_RELEASE : LS_ERROR;
`endif
      LS_RELEASE: if (r_rel_cnt == REL_W'(RELEASE_CYCLES - 1)) w_state_next = LS_DONE;
      default: w_state_next = r_state;
    endcase
  end

  always_comb begin
    byte_ready  = r_byte_ready;
    ram_addr    = r_addr;
    ram_data    = r_data;
    bus_owned   = !releases_bus(r_state);
    cpu_reset_n = (r_state == LS_DONE);
    done        = (r_state == LS_DONE);
`ifdef BOOT_SRAM_LOADER_CHECKSUM_EN
    error       = (r_state == LS_ERROR);
`else
    error       = 1'b0;
`endif
  end

endmodule

// File: tb/tb_boot_sram_loader.sv
// Scenario-table bench for boot_sram_loader with an SRAM/bus-protocol monitor and image model.
// A short image ending at 0xFFFF keeps runtime small and exercises the no-wrap address boundary.
module tb_boot_sram_loader;

  localparam int          ADDR_BITS = 16;
  localparam logic [15:0] BASE      = 16'hFF00;
  localparam int          LEN       = 256;
  localparam int          WE        = 2;
  localparam int          REL       = 16;
  localparam logic [15:0] LAST_ADDR = 16'hFFFF;
`ifdef BOOT_SRAM_LOADER_CHECKSUM_EN
  localparam int          NSCEN     = 4;
`else
  localparam int          NSCEN     = 3;
`endif

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic [7:0]           byte_data = 8'h00;
  logic                 byte_valid = 1'b0;
  logic                 byte_ready;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [7:0]           ram_data;
  logic                 ram_data_oe;
  logic                 ram_ce_n;
  logic                 ram_we_n;
  logic                 bus_owned;
  logic                 cpu_reset_n;
  logic                 done;
  logic                 error;

  boot_sram_loader #(
    .ADDR_BITS     (ADDR_BITS),
    .LOAD_BASE     (BASE),
    .LOAD_LENGTH   (LEN),
    .WE_CYCLES     (WE),
    .RELEASE_CYCLES(REL)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_data_oe(ram_data_oe),
    .ram_ce_n   (ram_ce_n),
    .ram_we_n   (ram_we_n),
    .bus_owned  (bus_owned),
    .cpu_reset_n(cpu_reset_n),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit rst_at_edge = 1'b1;

  always @(posedge clock) begin
    cyc++;
    rst_at_edge = !reset_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Image currently being loaded and the SRAM as seen through the bus.
  logic [7:0] stream [0:LEN-1];
  logic [7:0] mem    [0:65535];

  // Bus monitor: every write must present address/data/ce/oe one clock before we_n falls,
  // keep them through the strobe and one clock after we_n rises, in ascending address order.
  int          m_wr_count = 0;
  int          m_we_len = 0;
  int          m_idx = 0;
  logic        m_prev_we_n = 1'b1;
  logic        m_prev_ce_n = 1'b1;
  logic        m_prev_oe = 1'b0;
  logic [15:0] m_prev_addr = '0;
  logic [7:0]  m_prev_data = '0;
  logic [25:0] m_exp;

  always @(negedge clock) begin
    if (rst_at_edge) begin
      m_wr_count  = 0;
      m_we_len    = 0;
      m_prev_we_n = 1'b1;
      m_prev_ce_n = 1'b1;
      m_prev_oe   = 1'b0;
    end else begin
      m_idx = (m_wr_count < LEN) ? m_wr_count : LEN - 1;
      m_exp = {1'b0, 1'b1, BASE + 16'(m_idx), stream[m_idx]};
      if (!ram_we_n) begin
        if (m_prev_we_n) begin
          m_we_len = 0;
          chk("setup", 32'({m_prev_ce_n, m_prev_oe, m_prev_addr, m_prev_data}), 32'(m_exp));
        end
        m_we_len++;
        chk("strobe", 32'({ram_ce_n, ram_data_oe, ram_addr, ram_data}), 32'(m_exp));
      end else if (!m_prev_we_n) begin
        chk("we_low_clocks", 32'(m_we_len), 32'(WE));
        chk("hold", 32'({ram_ce_n, ram_data_oe, ram_addr, ram_data}), 32'(m_exp));
        mem[ram_addr] = ram_data;
        m_wr_count++;
      end
      m_prev_we_n = ram_we_n;
      m_prev_ce_n = ram_ce_n;
      m_prev_oe   = ram_data_oe;
      m_prev_addr = ram_addr;
      m_prev_data = ram_data;
    end
  end

  typedef struct {
    int pct;          // byte_valid duty in percent
    int abort_at;     // byte index whose strobe gets a reset pulse, -1 for none
    bit bad_sum;      // corrupt the trailing checksum byte
    bit random_data;  // random image instead of the i&0xFF ramp
    bit exp_done;
    bit exp_err;
  } scen_t;

  task automatic apply_reset();
    byte_valid = 1'b0;
    reset_n    = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_outputs", 32'({byte_ready, ram_data_oe, ram_ce_n, ram_we_n, bus_owned, cpu_reset_n, done, error}),
        32'(8'b0011_1000));
    chk("reset_addr_data", 32'({ram_addr, ram_data}), 32'({BASE, 8'h00}));
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_outputs", 32'({byte_ready, ram_data_oe, ram_ce_n, ram_we_n, bus_owned, cpu_reset_n, done, error}),
        32'(8'b1011_1000));
    chk("idle_addr", 32'(ram_addr), 32'(BASE));
  endtask

  task automatic run_scen(input scen_t sc);
    int         idx;
    int         guard;
    int         last_hs;
    int         t_rel;
    int         t_done;
    int         extra;
    int         hold_bad;
    int         n_hold;
    bit         aborted;
    bit         prev_hs;
    logic [7:0] sum;
`ifdef BOOT_SRAM_LOADER_CHECKSUM_EN
    logic [7:0] cs;
    bit         got;
`endif
    sum = 8'h00;
    for (int i = 0; i < LEN; i++) begin
      stream[i] = sc.random_data ? 8'($urandom) : 8'(i);
      sum += stream[i];
      mem[32'(BASE) + i] = ~stream[i];
    end
    apply_reset();

    idx = 0; guard = 0; last_hs = -1; aborted = 1'b0; prev_hs = 1'b0;
    while (idx < LEN && guard < 20000) begin
      @(negedge clock);
      guard++;
      if (prev_hs) chk("ready_drop", 32'(byte_ready), 32'(0));
      prev_hs = 1'b0;
      if (sc.abort_at >= 0 && !aborted && !ram_we_n && ram_addr == BASE + 16'(sc.abort_at)) begin
        byte_valid = 1'b0;
        reset_n    = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        aborted = 1'b1;
        idx     = 0;
        last_hs = -1;
        chk("abort_restart", 32'({ram_we_n, ram_ce_n, ram_addr}), 32'({1'b1, 1'b1, BASE}));
        continue;
      end
      byte_valid = ($urandom_range(0, 99) < 32'(sc.pct));
      byte_data  = stream[idx];
      if (byte_valid && byte_ready) begin
        if (sc.pct == 100 && last_hs >= 0) chk("handshake_spacing", 32'(cyc - last_hs), 32'(3 + WE));
        last_hs = cyc;
        idx++;
        prev_hs = 1'b1;
      end
    end
    chk("feed_complete", 32'(idx), 32'(LEN));

`ifdef BOOT_SRAM_LOADER_CHECKSUM_EN
    cs = sc.bad_sum ? (sum ^ 8'h01) : sum;
    got = 1'b0; guard = 0;
    while (!got && guard < 200) begin
      @(negedge clock);
      guard++;
      byte_valid = 1'b1;
      byte_data  = cs;
      if (byte_ready) got = 1'b1;
    end
    chk("checksum_accepted", 32'(got), 32'(1));
    @(negedge clock);
    byte_valid = 1'b0;
`else
    @(negedge clock);
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
`endif

    t_rel = -1; t_done = -1; extra = 0; guard = 0;
    while (!(done || error) && guard < 2000) begin
      @(negedge clock);
      guard++;
      if (!bus_owned && t_rel < 0) t_rel = cyc;
      if (done && t_done < 0) t_done = cyc;
      if (byte_valid && byte_ready) extra++;
    end
    chk("terminal_state", 32'({done, error, cpu_reset_n, bus_owned}),
        32'({sc.exp_done, sc.exp_err, sc.exp_done, 1'b0}));
    if (sc.exp_done) chk("release_to_done", 32'(t_done - t_rel), 32'(REL));
`ifndef BOOT_SRAM_LOADER_CHECKSUM_EN
    chk("extra_byte_taken", 32'(extra), 32'(0));
`endif

    // Terminal states ignore further bytes and hold their outputs.
    n_hold   = sc.exp_err ? 1000 : 20;
    hold_bad = 0;
    byte_valid = 1'b1;
    byte_data  = 8'h3C;
    for (int k = 0; k < n_hold; k++) begin
      @(negedge clock);
      if ({byte_ready, done, error, cpu_reset_n, bus_owned} !==
          {1'b0, sc.exp_done, sc.exp_err, sc.exp_done, 1'b0}) hold_bad++;
    end
    byte_valid = 1'b0;
    chk("terminal_hold", 32'(hold_bad), 32'(0));

    chk("write_count", 32'(m_wr_count), 32'(LEN));
    chk("final_addr_no_wrap", 32'(ram_addr), 32'(LAST_ADDR));
    for (int i = 0; i < LEN; i++) chk("image_byte", 32'(mem[32'(BASE) + i]), 32'(stream[i]));
    $display("scenario pct=%0d abort=%0d bad_sum=%0d -> done=%0b error=%0b writes=%0d",
             sc.pct, sc.abort_at, sc.bad_sum, done, error, m_wr_count);
  endtask

  initial begin
    scen_t tbl [NSCEN];
    tbl[0] = '{100, -1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{30, -1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{100, 100, 1'b0, 1'b1, 1'b1, 1'b0};
`ifdef BOOT_SRAM_LOADER_CHECKSUM_EN
    tbl[3] = '{100, -1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
    for (int s = 0; s < NSCEN; s++) run_scen(tbl[s]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
